dm_dma_arbiter: RTL

DM_DMA_ARBITER -- requirements
Module: dm_dma_arbiter

---
 rtl/dm_dma_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/dm_dma_arbiter.sv
// Shared data-memory port: the CPU always wins, and a byte-copy engine uses the
// cycles the CPU leaves idle, doing one read and then one write per byte.
module dm_dma_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [ADDR_W-1:0] dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, remaining;
  logic [DATA_W-1:0] data_buf;
  dm_req_t           eng_req, dm_req;

  // Engine request is all-zero outside RD/WR so the memory bus is quiet when idle.
  always_comb begin
    eng_req = '0;
    case (state)
      RD: eng_req.addr = src_ptr;
      WR: begin
        eng_req.we    = 1'b1;
        eng_req.addr  = dst_ptr;
        eng_req.wdata = data_buf;
      end
      default: ;
    endcase
    dm_req = eng_req;
    if (cpu_req) begin
      dm_req.we    = cpu_we;
      dm_req.addr  = cpu_addr;
      dm_req.wdata = cpu_wdata;
    end
  end

  assign dm_we     = dm_req.we;
  assign dm_addr   = dm_req.addr;
  assign dm_wdata  = dm_req.wdata;
  assign cpu_rdata = dm_rdata;

  // A CPU access in RD/WR simply freezes the engine for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_buf  <= '0;
      dma_busy  <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: if (dma_start) begin
          src_ptr   <= dma_src;
          dst_ptr   <= dma_dst;
          remaining <= dma_len;
          dma_busy  <= 1'b1;
          if (dma_len != '0) begin
            state <= RD;
          end else begin
            state    <= DONE;
            dma_done <= 1'b1;
          end
        end
        RD: if (!cpu_req) begin
          data_buf <= dm_rdata;
          state    <= WR;
        end
        WR: if (!cpu_req) begin
          src_ptr   <= src_ptr + ADDR_W'(1);
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
          if (remaining == ADDR_W'(1)) begin
            state    <= DONE;
            dma_done <= 1'b1;
          end else begin
            state <= RD;
          end
        end
        DONE: begin
          state    <= IDLE;
          dma_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
